gen_event_source: RTL and testbench

- Producer end of the event-trace interface.
- Accepts event requests from design logic and allocates a unique 64-bit event id for each one.
- Timestamps each event with a free-running 64-bit cycle counter and queues it in a small FIFO.
- Drains one event per handshake onto the id/parent/cycle/data/valid bus consumed by the event-export sink.
- Supports backpressure, or drop-on-full with a drop counter.

---
 rtl/gen_event_source.sv | 215 +++++++++++++++++++++
 tb/tb_gen_event_source.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gen_event_source.sv
// ---------------------------------------------------------------------------
// gen_event_source
//   Producer end of the event-trace interface. Each accepted request gets a
//   unique 64-bit id and a 64-bit cycle stamp, and is queued in a small FIFO
//   that drains one event per evt_valid/evt_ready handshake toward the
//   event-export sink.
//
// Parameters
//   DEPTH        FIFO entries (power of two, 2..16)
//   ID_BASE      first id handed out after reset (0 means "no parent")
//   DROP_ON_FULL 0: stall the requester while full; 1: discard and count
//
// Ports
//   clock       in   sole clock, rising edge
//   reset_n     in   synchronous active-low reset
//   req_valid   in   event request
//   req_ready   out  request can be taken this cycle
//   req_parent  in   parent event id (0 = root)
//   req_data    in   event payload
//   req_id      out  id the current request receives if accepted
//   evt_valid   out  event present on the sink bus
//   evt_ready   in   sink consumes the event
//   evt_id      out  event id
//   evt_parent  out  parent id
//   evt_cycle   out  cycle stamp
//   evt_data    out  payload
//   drop_count  out  saturating count of discarded requests
//   occupancy   out  FIFO fill level
// ---------------------------------------------------------------------------

// Protocol checker: fill level bound and output stability under backpressure.
module gen_event_source_chk #(
  parameter int unsigned     PW      = 3,
  parameter logic [PW-1:0]   DEPTH_W = PW'(4)
) (
  input logic          clock,
  input logic          reset_n,
  input logic          evt_valid,
  input logic          evt_ready,
  input logic [63:0]   evt_id,
  input logic [63:0]   evt_data,
  input logic [PW-1:0] occupancy
);

  a_occ_bound: assert property (@(posedge clock) disable iff (!reset_n)
    occupancy <= DEPTH_W);

  a_evt_hold: assert property (@(posedge clock) disable iff (!reset_n)
    (evt_valid && !evt_ready) |=> (evt_valid && $stable(evt_id) && $stable(evt_data)));

endmodule

module gen_event_source #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [63:0] ID_BASE      = 64'd1,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_parent,
  input  logic [63:0]              req_data,
  output logic [63:0]              req_id,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [63:0]              evt_id,
  output logic [63:0]              evt_parent,
  output logic [63:0]              evt_cycle,
  output logic [63:0]              evt_data,
  output logic [31:0]              drop_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  typedef struct packed {
    logic [63:0] id;
    logic [63:0] parent;
    logic [63:0] cycle;
    logic [63:0] data;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '{id: 64'd0, parent: 64'd0, cycle: 64'd0, data: 64'd0};

  // Full when the wrap bits differ and the index bits match.
  function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    ptr_full = (wr[PW-1] != rd[PW-1]) && (wr[PW-2:0] == rd[PW-2:0]);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc32 = v;
    end else begin
      sat_inc32 = v + 32'd1;
    end
  endfunction

  logic [63:0]   cycle_q,   cycle_d;
  logic [63:0]   next_id_q, next_id_d;
  logic [31:0]   drop_q,    drop_d;
  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  entry_t        mem_q [DEPTH];

  logic   full_s;
  logic   empty_s;
  logic   push_s;
  logic   pop_s;
  logic   drop_s;
  entry_t head_s;

  // Handshake qualification: readiness, push, pop and drop decisions.
  always_comb begin
    full_s  = ptr_full(wr_ptr_q, rd_ptr_q);
    empty_s = (wr_ptr_q == rd_ptr_q);
    if (!reset_n) begin
      req_ready = 1'b0;
    end else if (DROP_ON_FULL) begin
      req_ready = 1'b1;
    end else begin
      // A pop in the same cycle does not open a slot for the requester.
      req_ready = !full_s;
    end
    push_s = req_valid && req_ready && !full_s;
    // Only reachable in drop mode: accepted while full, so it is discarded.
    drop_s = req_valid && req_ready && full_s;
    pop_s  = reset_n && !empty_s && evt_ready;
  end

  // Next-state values for counters and pointers.
  always_comb begin
    cycle_d = cycle_q + 64'd1;
    if (push_s) begin
      next_id_d = next_id_q + 64'd1;
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
    end else begin
      next_id_d = next_id_q;
      wr_ptr_d  = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s) begin
      drop_d = sat_inc32(drop_q);
    end else begin
      drop_d = drop_q;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cycle_q   <= 64'd0;
      next_id_q <= ID_BASE;
      drop_q    <= 32'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      cycle_q   <= cycle_d;
      next_id_q <= next_id_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while empty since outputs are gated.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{id:     next_id_q,
                                   parent: req_parent,
                                   cycle:  cycle_q,
                                   data:   req_data};
    end
  end

  // Sink-side view of the FIFO head, forced to zero while empty.
  always_comb begin
    head_s = mem_q[rd_ptr_q[AW-1:0]];
    if (empty_s) begin
      head_s = ENTRY_ZERO;
    end else begin
      head_s = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign req_id     = next_id_q;
  assign evt_valid  = !empty_s;
  assign evt_id     = head_s.id;
  assign evt_parent = head_s.parent;
  assign evt_cycle  = head_s.cycle;
  assign evt_data   = head_s.data;
  assign drop_count = drop_q;
  assign occupancy  = wr_ptr_q - rd_ptr_q;

  gen_event_source_chk #(
    .PW      (PW),
    .DEPTH_W (PW'(DEPTH))
  ) u_chk (
    .clock     (clock),
    .reset_n   (reset_n),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_data  (evt_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_gen_event_source.sv
// ---------------------------------------------------------------------------
// tb_gen_event_source
//   Drives a stalling instance (DROP_ON_FULL=0) and a dropping instance
//   (DROP_ON_FULL=1) with identical stimulus. A scoreboard queue per instance
//   holds the expected events; a vector table carries hand-computed fill
//   levels, readiness, drop counts and ids for the backpressure scenario.
// ---------------------------------------------------------------------------
module tb_gen_event_source;

  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        req_valid;
  logic        evt_ready;
  logic [63:0] req_parent;
  logic [63:0] req_data;

  logic          rdy0, ev0, rdy1, ev1;
  logic [63:0]   rid0, eid0, epar0, ecyc0, edat0;
  logic [63:0]   rid1, eid1, epar1, ecyc1, edat1;
  logic [31:0]   drop0, drop1;
  logic [OW-1:0] occ0, occ1;

  gen_event_source #(.DEPTH(DEPTH), .ID_BASE(64'd1), .DROP_ON_FULL(1'b0)) u_stall (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy0), .req_parent(req_parent),
    .req_data(req_data), .req_id(rid0),
    .evt_valid(ev0), .evt_ready(evt_ready), .evt_id(eid0), .evt_parent(epar0),
    .evt_cycle(ecyc0), .evt_data(edat0), .drop_count(drop0), .occupancy(occ0)
  );

  gen_event_source #(.DEPTH(DEPTH), .ID_BASE(64'd1), .DROP_ON_FULL(1'b1)) u_drop (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy1), .req_parent(req_parent),
    .req_data(req_data), .req_id(rid1),
    .evt_valid(ev1), .evt_ready(evt_ready), .evt_id(eid1), .evt_parent(epar1),
    .evt_cycle(ecyc1), .evt_data(edat1), .drop_count(drop1), .occupancy(occ1)
  );

  typedef struct {
    logic [63:0] id;
    logic [63:0] parent;
    logic [63:0] cyc;
    logic [63:0] data;
  } ev_t;

  typedef struct {
    logic        rv;
    logic        er;
    int          occ0;
    logic        rdy0;
    int          occ1;
    int          drop1;
    logic [63:0] rid;
  } vec_t;

  ev_t         q0[$];
  ev_t         q1[$];
  logic [63:0] mid0, mid1, mcyc;
  logic [31:0] mdrop1;
  int          checks   = 0;
  int          failures = 0;
  vec_t        tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_dut(input string tag, input int sz, input ev_t head,
                             input logic [63:0] exp_id, input logic [31:0] exp_drop,
                             input logic exp_rdy,
                             input logic rdy, input logic [63:0] rid, input logic v,
                             input logic [63:0] eid, input logic [63:0] epar,
                             input logic [63:0] ecyc, input logic [63:0] edat,
                             input logic [31:0] drp, input logic [OW-1:0] occ);
    chk({tag, "_req_ready"}, 64'(rdy), 64'(exp_rdy));
    chk({tag, "_req_id"}, rid, exp_id);
    chk({tag, "_occupancy"}, 64'(occ), 64'(sz));
    chk({tag, "_evt_valid"}, 64'(v), 64'(sz != 0));
    chk({tag, "_evt_id"}, eid, head.id);
    chk({tag, "_evt_parent"}, epar, head.parent);
    chk({tag, "_evt_cycle"}, ecyc, head.cyc);
    chk({tag, "_evt_data"}, edat, head.data);
    chk({tag, "_drop_count"}, 64'(drp), 64'(exp_drop));
  endtask

  // One clock cycle: drive, compare against the scoreboard, then advance it.
  task automatic step(input logic rv, input logic er, input logic [63:0] par, input logic [63:0] dat);
    ev_t  h0, h1;
    logic acc0, acc1, drp1, pop0, pop1;
    req_valid  = rv;
    evt_ready  = er;
    req_parent = par;
    req_data   = dat;
    #1;
    h0 = '{id: 64'd0, parent: 64'd0, cyc: 64'd0, data: 64'd0};
    h1 = h0;
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    compare_dut("stall", q0.size(), h0, mid0, 32'd0, q0.size() < DEPTH,
                rdy0, rid0, ev0, eid0, epar0, ecyc0, edat0, drop0, occ0);
    compare_dut("drop", q1.size(), h1, mid1, mdrop1, 1'b1,
                rdy1, rid1, ev1, eid1, epar1, ecyc1, edat1, drop1, occ1);
    acc0 = rv && (q0.size() < DEPTH);
    acc1 = rv && (q1.size() < DEPTH);
    drp1 = rv && (q1.size() == DEPTH);
    pop0 = er && (q0.size() > 0);
    pop1 = er && (q1.size() > 0);
    @(posedge clock);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (acc0) begin
      q0.push_back('{id: mid0, parent: par, cyc: mcyc, data: dat});
      mid0 = mid0 + 64'd1;
    end
    if (acc1) begin
      q1.push_back('{id: mid1, parent: par, cyc: mcyc, data: dat});
      mid1 = mid1 + 64'd1;
    end
    if (drp1 && (mdrop1 != 32'hFFFF_FFFF)) mdrop1 = mdrop1 + 32'd1;
    mcyc = mcyc + 64'd1;
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset_n    = 1'b0;
    req_valid  = 1'b1;
    evt_ready  = 1'b0;
    req_parent = 64'd0;
    req_data   = 64'd0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_req_ready_stall", 64'(rdy0), 64'd0);
      chk("rst_req_ready_drop", 64'(rdy1), 64'd0);
      @(posedge clock);
      @(negedge clock);
    end
    q0.delete();
    q1.delete();
    mid0      = 64'd1;
    mid1      = 64'd1;
    mdrop1    = 32'd0;
    mcyc      = 64'd0;
    req_valid = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    //            rv    er    occ0 rdy0  occ1 drop1 rid
    tbl[0]  = '{1'b1, 1'b0, 0, 1'b1, 0, 0, 64'd1};
    tbl[1]  = '{1'b1, 1'b0, 1, 1'b1, 1, 0, 64'd2};
    tbl[2]  = '{1'b1, 1'b0, 2, 1'b1, 2, 0, 64'd3};
    tbl[3]  = '{1'b1, 1'b0, 3, 1'b1, 3, 0, 64'd4};
    tbl[4]  = '{1'b1, 1'b0, 4, 1'b0, 4, 0, 64'd5};
    tbl[5]  = '{1'b1, 1'b0, 4, 1'b0, 4, 1, 64'd5};
    tbl[6]  = '{1'b0, 1'b0, 4, 1'b0, 4, 2, 64'd5};
    tbl[7]  = '{1'b1, 1'b1, 4, 1'b0, 4, 2, 64'd5};
    tbl[8]  = '{1'b1, 1'b1, 3, 1'b1, 3, 3, 64'd5};
    tbl[9]  = '{1'b0, 1'b1, 3, 1'b1, 3, 3, 64'd6};
    tbl[10] = '{1'b0, 1'b1, 2, 1'b1, 2, 3, 64'd6};
    tbl[11] = '{1'b0, 1'b1, 1, 1'b1, 1, 3, 64'd6};
    tbl[12] = '{1'b0, 1'b1, 0, 1'b1, 0, 3, 64'd6};
    tbl[13] = '{1'b0, 1'b1, 0, 1'b1, 0, 3, 64'd6};

    // Reset, five idle cycles, then one request stamped at cycle 5.
    do_reset(2);
    #1;
    chk("reset_evt_valid", 64'(ev0), 64'd0);
    chk("reset_occupancy", 64'(occ0), 64'd0);
    chk("reset_evt_data", edat0, 64'd0);
    @(negedge clock);
    mcyc = 64'd1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("first_req_id", rid0, 64'd1);
    step(1'b1, 1'b0, 64'd0, 64'hAB);
    #1;
    chk("first_evt_valid", 64'(ev0), 64'd1);
    chk("first_evt_id", eid0, 64'd1);
    chk("first_evt_parent", epar0, 64'd0);
    chk("first_evt_cycle", ecyc0, 64'd5);
    chk("first_evt_data", edat0, 64'hAB);
    step(1'b0, 1'b1, 64'd0, 64'd0);
    #1;
    chk("first_pop_valid", 64'(ev0), 64'd0);
    chk("first_pop_occ", 64'(occ0), 64'd0);

    // Backpressure, drop-on-full and full-with-pop vectors.
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      #1;
      chk($sformatf("tbl%0d_occ_stall", i), 64'(occ0), 64'(tbl[i].occ0));
      chk($sformatf("tbl%0d_rdy_stall", i), 64'(rdy0), 64'(tbl[i].rdy0));
      chk($sformatf("tbl%0d_occ_drop", i), 64'(occ1), 64'(tbl[i].occ1));
      chk($sformatf("tbl%0d_drop_count", i), 64'(drop1), 64'(tbl[i].drop1));
      chk($sformatf("tbl%0d_rid_stall", i), rid0, tbl[i].rid);
      chk($sformatf("tbl%0d_rid_drop", i), rid1, tbl[i].rid);
      step(tbl[i].rv, tbl[i].er, 64'h100 + 64'(i), 64'hD000 + 64'(i));
    end

    // Steady streaming with parent chaining.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, mid0 - 64'd1, 64'h5000 + 64'(i));
      #1;
      chk("stream_occ", 64'(occ0), 64'd1);
      chk("stream_cycle", ecyc0, mcyc - 64'd1);
    end
    step(1'b0, 1'b1, 64'd0, 64'd0);

    // Reset while three events are queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'd7, 64'hE0 + 64'(i));
    #1;
    chk("pre_rst_occ", 64'(occ0), 64'd3);
    do_reset(1);
    #1;
    chk("mid_rst_evt_valid", 64'(ev0), 64'd0);
    chk("mid_rst_drop_count", 64'(drop1), 64'd0);
    chk("mid_rst_req_id", rid0, 64'd1);
    chk("mid_rst_occ", 64'(occ1), 64'd0);
    step(1'b1, 1'b0, 64'd0, 64'hCC);
    #1;
    chk("post_rst_cycle", ecyc0, 64'd0);
    chk("post_rst_id", eid0, 64'd1);
    step(1'b0, 1'b1, 64'd0, 64'd0);
    step(1'b0, 1'b1, 64'd0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
